// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner: synchronizes, debounces and qualifies the four game
// buttons into single-cycle colour press events or multi-press flags.
module btn_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_green,
    input  logic       btn_red,
    input  logic       btn_blue,
    input  logic       btn_yellow,
    input  logic       enable,
    output logic       press_valid,
    output logic [1:0] press_color,
    output logic       multi_press,
    output logic       any_held
);

    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BTN_W     = 4;

    localparam logic [1:0] COLOR_GREEN  = 2'd0;
    localparam logic [1:0] COLOR_RED    = 2'd1;
    localparam logic [1:0] COLOR_BLUE   = 2'd2;
    localparam logic [1:0] COLOR_YELLOW = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic [BTN_W-1:0] raw_vec;
    logic [BTN_W-1:0] sync_q [SYNC_STAGES];
    logic [BTN_W-1:0] sync_d [SYNC_STAGES];
    logic [BTN_W-1:0] sync_vec;

    logic [BTN_W-1:0]     prev_q, prev_d;
    logic [BTN_W-1:0]     db_q, db_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] run_len;

    state_t state_q, state_d;

    logic       press_valid_q, press_valid_d;
    logic [1:0] press_color_q, press_color_d;
    logic       multi_press_q, multi_press_d;
    logic       any_held_q, any_held_d;

    logic       one_hot;
    logic [1:0] enc_color;

    assign raw_vec  = {btn_yellow, btn_blue, btn_red, btn_green};
    assign sync_vec = sync_q[SYNC_STAGES-1];

    // Shift chain of the multi-stage synchronizer
    always_comb begin
        sync_d[0] = raw_vec;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchronizer flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Debounce: accept sync_vec once it has held steady for DEBOUNCE_CYCLES cycles
    always_comb begin
        prev_d  = sync_vec;
        db_d    = db_q;
        cnt_d   = cnt_q;
        run_len = (sync_vec != prev_q) ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
        if (sync_vec == db_q) begin
            cnt_d = '0;
        end else if (run_len == CNT_WIDTH'(DEBOUNCE_CYCLES)) begin
            db_d  = sync_vec;
            cnt_d = '0;
        end else begin
            cnt_d = run_len;
        end
    end

    // Debounce registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            db_q   <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave idle on any debounced press, return once all released
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (db_q != '0) state_d = ST_HELD;
            ST_HELD: if (db_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single-bit detect and colour encoding of the debounced vector
    always_comb begin
        one_hot = (db_q != '0) && ((db_q & (db_q - BTN_W'(1))) == '0);
        case (db_q)
            4'b0001: enc_color = COLOR_GREEN;
            4'b0010: enc_color = COLOR_RED;
            4'b0100: enc_color = COLOR_BLUE;
            4'b1000: enc_color = COLOR_YELLOW;
            default: enc_color = COLOR_GREEN;
        endcase
    end

    // Output decode: events only on the idle-to-held qualification
    always_comb begin
        press_valid_d = 1'b0;
        multi_press_d = 1'b0;
        press_color_d = press_color_q;
        any_held_d    = (db_q != '0);
        if (state_q == ST_IDLE && db_q != '0) begin
            if (one_hot) begin
                if (enable) begin
                    press_valid_d = 1'b1;
                    press_color_d = enc_color;
                end
            end else begin
                multi_press_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_valid_q <= 1'b0;
            press_color_q <= 2'b00;
            multi_press_q <= 1'b0;
            any_held_q    <= 1'b0;
        end else begin
            press_valid_q <= press_valid_d;
            press_color_q <= press_color_d;
            multi_press_q <= multi_press_d;
            any_held_q    <= any_held_d;
        end
    end

    assign press_valid = press_valid_q;
    assign press_color = press_color_q;
    assign multi_press = multi_press_q;
    assign any_held    = any_held_q;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Bench for btn_input_conditioner: directed scenarios plus random button
// activity, checked every cycle against a window-based behavioural model.
module tb_btn_input_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned S = 2;

    logic       clk;
    logic       rst_n;
    logic       btn_green, btn_red, btn_blue, btn_yellow;
    logic       enable;
    logic       press_valid;
    logic [1:0] press_color;
    logic       multi_press;
    logic       any_held;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    btn_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_green  (btn_green),
        .btn_red    (btn_red),
        .btn_blue   (btn_blue),
        .btn_yellow (btn_yellow),
        .enable     (enable),
        .press_valid(press_valid),
        .press_color(press_color),
        .multi_press(multi_press),
        .any_held   (any_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_btn(input logic [3:0] v);
        {btn_yellow, btn_blue, btn_red, btn_green} = v;
    endtask

    // Behavioural model: raw samples delayed S edges, accepted once the last
    // D samples seen agree and differ from the accepted vector.
    bit [3:0] m_rq[$];
    bit [3:0] m_win[$];
    bit [3:0] m_db;
    bit [3:0] m_seen;
    bit       m_held;
    bit       m_same;
    bit       e_pv, e_mp, e_ah;
    bit [1:0] e_col;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rq.delete();
            for (int i = 0; i < S; i++) m_rq.push_back(4'b0);
            m_win.delete();
            m_db   = '0;
            m_held = 1'b0;
            e_pv   = 1'b0;
            e_mp   = 1'b0;
            e_ah   = 1'b0;
            e_col  = '0;
        end else begin
            e_pv = 1'b0;
            e_mp = 1'b0;
            e_ah = (m_db != 0);
            if (!m_held && m_db != 0) begin
                m_held = 1'b1;
                if ($countones(m_db) == 1) begin
                    if (enable) begin
                        e_pv = 1'b1;
                        for (int i = 0; i < 4; i++) if (m_db[i]) e_col = 2'(i);
                    end
                end else begin
                    e_mp = 1'b1;
                end
            end else if (m_held && m_db == 0) begin
                m_held = 1'b0;
            end
            m_seen = m_rq.pop_front();
            m_rq.push_back({btn_yellow, btn_blue, btn_red, btn_green});
            m_win.push_back(m_seen);
            if (m_win.size() > D) void'(m_win.pop_front());
            if (m_win.size() == D) begin
                m_same = 1'b1;
                foreach (m_win[i]) if (m_win[i] != m_win[0]) m_same = 1'b0;
                if (m_same && m_win[0] != m_db) m_db = m_win[0];
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("press_valid", 32'(press_valid), 32'(e_pv));
        chk("multi_press", 32'(multi_press), 32'(e_mp));
        chk("any_held", 32'(any_held), 32'(e_ah));
        if (e_pv) chk("press_color", 32'(press_color), 32'(e_col));
    end

    // Event monitor feeding the directed expectations
    int pv_cnt = 0;
    int mp_cnt = 0;
    int last_pv_cyc = 0;
    int col_q[$];

    always @(negedge clk) begin
        if (press_valid === 1'b1) begin
            pv_cnt++;
            last_pv_cyc = cyc;
            col_q.push_back(int'(press_color));
        end
        if (multi_press === 1'b1) mp_cnt++;
    end

    function automatic int first_col();
        return (col_q.size() > 0) ? col_q[0] : 9;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c0, p0, m0;
    logic [3:0] rv;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        set_btn(4'b0000);
        wait_cyc(3);
        #1;
        chk("rst_press_valid", 32'(press_valid), 0);
        chk("rst_press_color", 32'(press_color), 0);
        chk("rst_multi_press", 32'(multi_press), 0);
        chk("rst_any_held", 32'(any_held), 0);
        #1 rst_n = 1'b1;
        wait_cyc(5);

        // Clean red press
        col_q.delete(); p0 = pv_cnt; m0 = mp_cnt;
        set_btn(4'b0010); c0 = cyc;
        wait_cyc(20);
        set_btn(4'b0000);
        wait_cyc(15); #1;
        chk("clean_count", pv_cnt - p0, 1);
        chk("clean_latency", last_pv_cyc - c0, 7);
        chk("clean_color", first_col(), 1);
        chk("clean_multi", mp_cnt - m0, 0);
        chk("clean_released", 32'(any_held), 0);

        // Bouncing blue press with a short glitch mid-hold
        @(negedge clk);
        col_q.delete(); p0 = pv_cnt;
        for (int i = 0; i < 6; i++) begin
            set_btn((i % 2 == 0) ? 4'b0100 : 4'b0000);
            wait_cyc(1);
        end
        set_btn(4'b0100); c0 = cyc;
        wait_cyc(10);
        set_btn(4'b0000);
        wait_cyc(2);
        set_btn(4'b0100);
        wait_cyc(6);
        set_btn(4'b0000);
        wait_cyc(15); #1;
        chk("bounce_count", pv_cnt - p0, 1);
        chk("bounce_latency", last_pv_cyc - c0, 7);
        chk("bounce_color", first_col(), 2);

        // Green and yellow together, then yellow released
        @(negedge clk);
        p0 = pv_cnt; m0 = mp_cnt;
        set_btn(4'b1001);
        wait_cyc(10);
        set_btn(4'b0001);
        wait_cyc(10);
        set_btn(4'b0000);
        wait_cyc(15); #1;
        chk("multi_count", mp_cnt - m0, 1);
        chk("multi_no_press", pv_cnt - p0, 0);

        // Enable gating
        @(negedge clk);
        p0 = pv_cnt;
        enable = 1'b0;
        set_btn(4'b0001);
        wait_cyc(10);
        enable = 1'b1;
        wait_cyc(10);
        set_btn(4'b0000);
        wait_cyc(15); #1;
        chk("gated_count", pv_cnt - p0, 0);
        @(negedge clk);
        col_q.delete(); p0 = pv_cnt;
        set_btn(4'b0001);
        wait_cyc(10);
        set_btn(4'b0000);
        wait_cyc(15); #1;
        chk("regate_count", pv_cnt - p0, 1);
        chk("regate_color", first_col(), 0);

        // Back-to-back colours
        @(negedge clk);
        col_q.delete(); p0 = pv_cnt;
        for (int i = 0; i < 4; i++) begin
            set_btn(4'(1 << i));
            wait_cyc(10);
            set_btn(4'b0000);
            wait_cyc(10);
        end
        wait_cyc(5); #1;
        chk("b2b_count", pv_cnt - p0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_color", (col_q.size() > i) ? col_q[i] : 9, i);
        end

        // Reset while yellow is held
        @(negedge clk);
        set_btn(4'b1000);
        wait_cyc(10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_press_valid", 32'(press_valid), 0);
        chk("midrst_press_color", 32'(press_color), 0);
        chk("midrst_multi_press", 32'(multi_press), 0);
        chk("midrst_any_held", 32'(any_held), 0);
        col_q.delete(); p0 = pv_cnt;
        wait_cyc(2);
        #2 rst_n = 1'b1; c0 = cyc;
        wait_cyc(10);
        set_btn(4'b0000);
        wait_cyc(15); #1;
        chk("midrst_count", pv_cnt - p0, 1);
        chk("midrst_latency", last_pv_cyc - c0, 7);
        chk("midrst_color", first_col(), 3);

        // Random activity with occasional resets
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            case ($urandom_range(0, 9))
                0, 1, 2:    rv = 4'b0000;
                3, 4, 5, 6: rv = 4'(1 << $urandom_range(0, 3));
                default:    rv = 4'($urandom_range(0, 15));
            endcase
            set_btn(rv);
            enable = ($urandom_range(0, 3) != 0);
            wait_cyc($urandom_range(0, 11));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        set_btn(4'b0000);
        wait_cyc(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
